// File: rtl/counter_sweep_pkg.sv
// Shared definitions for the counter sweep controller: state encodings and
// default datapath widths.
package counter_sweep_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_SW_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/counter_sweep_ctrl_counter.sv
// WIDTH-bit up/down counter with synchronous load and enable; owns the
// count register that the sweep controller steers.
module updown_counter_ld
   import counter_sweep_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic             up,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count
);

   // NOTE: sequential state is written with <= so every register samples
   // the pre-edge value of its inputs, regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= up ? count + 1'b1 : count - 1'b1;
      end
   end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Triangular sweep sequencer driving updown_counter_ld between latched limits.
// Optional hold/freeze input is enabled by defining COUNTER_SWEEP_HOLD_EN.
module counter_sweep_ctrl
   import counter_sweep_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SW_W  = DEF_SW_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] lo_limit,
   input  logic [WIDTH-1:0] hi_limit,
   input  logic [SW_W-1:0]  n_sweeps,
   input  logic             abort,
`ifdef COUNTER_SWEEP_HOLD_EN
   input  logic             hold,
`endif
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [SW_W-1:0]  sweep_cnt
);

   state_t            state;
   logic [WIDTH-1:0]  lo_q, hi_q;
   logic [SW_W-1:0]   n_q;
   logic [SW_W-1:0]   sweep_nxt;
   logic              hold_act, start_ok, at_hi, at_lo, last_sweep, active;
   logic              cnt_load, cnt_en, cnt_up;

`ifdef COUNTER_SWEEP_HOLD_EN
   assign hold_act = hold;
`else
   assign hold_act = 1'b0;
`endif

   assign start_ok   = (lo_limit < hi_limit) && (n_sweeps != '0);
   assign at_hi      = (count == hi_q);
   assign at_lo      = (count == lo_q);
   assign sweep_nxt  = sweep_cnt + 1'b1;
   assign last_sweep = at_lo && (sweep_nxt == n_q);
   assign active     = ((state == UP) || (state == DOWN)) && !abort && !hold_act;

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      cnt_up   = 1'b1;
      if ((state == IDLE) && start && start_ok) begin
         cnt_load = 1'b1;
      end else if (active) begin
         if (state == UP) begin
            cnt_en = 1'b1;
            cnt_up = !at_hi;
         end else begin
            cnt_en = !last_sweep;
            cnt_up = at_lo;
         end
      end
   end

   updown_counter_ld #(.WIDTH(WIDTH)) u_counter (
      .clk      (clk),
      .rst_n    (reset),
      .load     (cnt_load),
      .en       (cnt_en),
      .up       (cnt_up),
      .load_val (lo_limit),
      .count    (count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         lo_q      <= '0;
         hi_q      <= '0;
         n_q       <= '0;
         dir       <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         sweep_cnt <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (start_ok) begin
                     lo_q      <= lo_limit;
                     hi_q      <= hi_limit;
                     n_q       <= n_sweeps;
                     dir       <= 1'b1;
                     sweep_cnt <= '0;
                     busy      <= 1'b1;
                     state     <= UP;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            UP, DOWN: begin
               // abort outranks both hold and limit detection
               if (abort) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else if (!hold_act) begin
                  if (state == UP) begin
                     if (at_hi) begin
                        dir   <= 1'b0;
                        state <= DOWN;
                     end
                  end else if (at_lo) begin
                     sweep_cnt <= sweep_nxt;
                     if (last_sweep) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                     end else begin
                        dir   <= 1'b1;
                        state <= UP;
                     end
                  end
               end
            end
            DONE: begin
               dir   <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Scoreboard bench for counter_sweep_ctrl: directed runs push hand-computed
// output frames, a negedge monitor pops and compares each presented frame.
module tb_counter_sweep_ctrl;

   typedef struct packed {
      logic [7:0] count;
      logic       dir;
      logic       busy;
      logic       done;
      logic       err;
      logic [3:0] sweep;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] lo_limit = '0;
   logic [7:0] hi_limit = '0;
   logic [3:0] n_sweeps = '0;
`ifdef COUNTER_SWEEP_HOLD_EN
   logic       hold = 1'b0;
`endif
   logic [7:0] count;
   logic       dir, busy, done, err;
   logic [3:0] sweep_cnt;

   obs_t exp_q[$];
   obs_t act;
   int   checks = 0;
   int   errors = 0;
   int   frame  = 0;

   assign act = {count, dir, busy, done, err, sweep_cnt};

   counter_sweep_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .lo_limit  (lo_limit),
      .hi_limit  (hi_limit),
      .n_sweeps  (n_sweeps),
      .abort     (abort),
`ifdef COUNTER_SWEEP_HOLD_EN
      .hold      (hold),
`endif
      .count     (count),
      .dir       (dir),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .sweep_cnt (sweep_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic push(input int c, input int d, input int b, input int dn, input int e, input int s);
      exp_q.push_back({8'(c), 1'(d), 1'(b), 1'(dn), 1'(e), 4'(s)});
   endtask

   task automatic start_run(input int lo, input int hi, input int n);
      @(negedge clk);
      lo_limit = 8'(lo);
      hi_limit = 8'(hi);
      n_sweeps = 4'(n);
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) check({name, "_timeout"}, exp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   // Monitor: any cycle with busy/done/err is a presented frame.
   initial begin
      forever begin
         @(negedge clk);
         if (reset && (busy || done || err)) begin
            frame++;
            if (exp_q.size() == 0) check($sformatf("unexpected_frame%0d", frame), act, 0);
            else                   check($sformatf("frame%0d", frame), act, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_count", count, 0);
      check("rst_dir", dir, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_sweep", sweep_cnt, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // lo=0 hi=3 n=1
      push(0,1,1,0,0,0); push(1,1,1,0,0,0); push(2,1,1,0,0,0); push(3,1,1,0,0,0);
      push(2,0,1,0,0,0); push(1,0,1,0,0,0); push(0,0,1,0,0,0);
      push(0,0,0,1,0,1);
      start_run(0, 3, 1);
      drain("run1");

      // lo=2 hi=4 n=2
      push(2,1,1,0,0,0); push(3,1,1,0,0,0); push(4,1,1,0,0,0); push(3,0,1,0,0,0);
      push(2,0,1,0,0,0); push(3,1,1,0,0,1); push(4,1,1,0,0,1); push(3,0,1,0,0,1);
      push(2,0,1,0,0,1);
      push(2,0,0,1,0,2);
      start_run(2, 4, 2);
      drain("run2");

      // Rejected starts: equal limits, then zero sweeps
      push(2,1,0,0,1,2);
      start_run(5, 5, 1);
      drain("err_eq");
      push(2,1,0,0,1,2);
      start_run(1, 3, 0);
      drain("err_n0");

      // lo=0 hi=10 n=3, abort while count=6 in UP; a start mid-run is ignored
      for (int i = 0; i <= 6; i++) push(i,1,1,0,0,0);
      push(6,1,0,1,0,0);
      start_run(0, 10, 3);
      repeat (2) @(negedge clk);
      lo_limit = 8'd1; hi_limit = 8'd2; n_sweeps = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      drain("abort");

      // Reset mid-run at count=5: outputs clear, no done pulse
      for (int i = 0; i <= 5; i++) push(i,1,1,0,0,0);
      start_run(0, 10, 1);
      repeat (5) @(negedge clk);
      #1 reset = 1'b0;
      #1;
      check("midrst_count", count, 0);
      check("midrst_dir", dir, 1);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_sweep", sweep_cnt, 0);
      @(negedge clk);
      reset = 1'b1;
      drain("midrst");

`ifdef COUNTER_SWEEP_HOLD_EN
      // lo=0 hi=5 n=1, hold three edges at count=2
      push(0,1,1,0,0,0); push(1,1,1,0,0,0);
      for (int i = 0; i < 4; i++) push(2,1,1,0,0,0);
      push(3,1,1,0,0,0); push(4,1,1,0,0,0); push(5,1,1,0,0,0);
      push(4,0,1,0,0,0); push(3,0,1,0,0,0); push(2,0,1,0,0,0); push(1,0,1,0,0,0);
      push(0,0,1,0,0,0);
      push(0,0,0,1,0,1);
      start_run(0, 5, 1);
      repeat (2) @(negedge clk);
      hold = 1'b1;
      repeat (3) @(negedge clk);
      hold = 1'b0;
      drain("hold");

      // hold and abort together at count=1
      push(0,1,1,0,0,0); push(1,1,1,0,0,0);
      push(1,1,0,1,0,0);
      start_run(0, 5, 1);
      @(negedge clk);
      hold = 1'b1; abort = 1'b1;
      @(negedge clk);
      hold = 1'b0; abort = 1'b0;
      drain("hold_abort");
`endif

      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
